// File: rtl/charset_fetch_sequencer.sv
// Text-mode character fetch sequencer: VRAM code fetch, charset ROM read, one-cell-ahead
// prefetch and MSB-first pixel shifter. Build macro CHARSET_INVERSE_EN: code bit 7 = inverse video.
module charset_fetch_sequencer #(
    parameter int unsigned AW   = 13,
    parameter int unsigned DW   = 8,
    parameter int unsigned COLS = 40
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          line_start,
    input  logic [15:0]   line_base,
    input  logic [2:0]    row,
    input  logic [1:0]    bank,
    output logic          vram_req,
    output logic [15:0]   vram_addr,
    input  logic          vram_ack,
    input  logic [7:0]    vram_data,
    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          pix,
    output logic          pix_valid,
    output logic          busy,
    output logic          underrun
);
    localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [7:0]    LAST_COL = 8'(COLS - 1);
    localparam logic [7:0]    NUM_COLS = 8'(COLS);

    typedef enum logic [2:0] {IDLE, VREQ, ROMRD, ROMCAP, HOLD} state_t;

    state_t          state;
    logic            restart;
    logic [15:0]     base_q;
    logic [2:0]      row_q;
    logic [1:0]      bank_q;
    logic [7:0]      fetch_col;
    logic [7:0]      disp_cnt;
    logic [DW-1:0]   pf_data;
    logic            buf_full;
    logic [DW-1:0]   shreg;
    logic [BW-1:0]   bit_cnt;

    logic            boundary_c;
    logic            end_c;
    logic            first_c;
    logic            load_c;
    logic            urun_c;
    logic [7:0]      disp_next_c;
    logic            capture_c;
    logic [AW-1:0]   rom_addr_c;
    logic [DW-1:0]   glyph_c;

`ifdef CHARSET_INVERSE_EN
    logic            inv_q;
    assign rom_addr_c = AW'({bank_q, 1'b0, vram_data[6:0], row_q});
    assign glyph_c    = inv_q ? ~rom_q : rom_q;
`else
    assign rom_addr_c = AW'({bank_q, vram_data, row_q});
    assign glyph_c    = rom_q;
`endif

    // Cell-boundary decode; disp_next_c counts the cell that starts on this edge, so a
    // late byte for a slot already shown as an underrun is dropped rather than shown later.
    assign boundary_c  = pix_valid && ce && (bit_cnt == LAST_BIT);
    assign end_c       = boundary_c && (disp_cnt == NUM_COLS);
    assign first_c     = !pix_valid && busy && buf_full && ce && (disp_cnt == 8'd0);
    assign load_c      = first_c || (boundary_c && !end_c && buf_full);
    assign urun_c      = boundary_c && !end_c && !buf_full;
    assign disp_next_c = disp_cnt + {7'd0, (load_c || urun_c)};
    assign capture_c   = (state == ROMCAP) && (fetch_col >= disp_next_c);
    assign pix         = shreg[DW-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            restart   <= 1'b0;
            base_q    <= '0;
            row_q     <= '0;
            bank_q    <= '0;
            fetch_col <= '0;
            disp_cnt  <= '0;
            pf_data   <= '0;
            buf_full  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            vram_req  <= 1'b0;
            vram_addr <= '0;
            rom_ce    <= 1'b0;
            rom_addr  <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
`ifdef CHARSET_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else if (line_start) begin
            // An active line is aborted with one request-free cycle before the restart.
            base_q    <= line_base;
            row_q     <= row;
            bank_q    <= bank;
            fetch_col <= '0;
            disp_cnt  <= '0;
            buf_full  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            rom_ce    <= 1'b0;
            pix_valid <= 1'b0;
            busy      <= 1'b1;
            underrun  <= 1'b0;
            vram_addr <= line_base;
            if (state == IDLE && !busy) begin
                state    <= VREQ;
                vram_req <= 1'b1;
                restart  <= 1'b0;
            end else begin
                state    <= IDLE;
                vram_req <= 1'b0;
                restart  <= 1'b1;
            end
        end else begin
            rom_ce <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) begin
                        state    <= VREQ;
                        vram_req <= 1'b1;
                        restart  <= 1'b0;
                    end
                end
                VREQ: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        rom_ce   <= 1'b1;
                        rom_addr <= rom_addr_c;
`ifdef CHARSET_INVERSE_EN
                        inv_q    <= vram_data[7];
`endif
                        state    <= ROMRD;
                    end
                end
                ROMRD: state <= ROMCAP;
                ROMCAP: begin
                    if (fetch_col == LAST_COL) begin
                        state <= IDLE;
                    end else begin
                        fetch_col <= fetch_col + 8'd1;
                        vram_addr <= base_q + 16'(fetch_col) + 16'd1;
                        if (capture_c) begin
                            state <= HOLD;
                        end else begin
                            state    <= VREQ;
                            vram_req <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!buf_full) begin
                        state    <= VREQ;
                        vram_req <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Pixel shifter and cell accounting.
            if (end_c) begin
                shreg     <= '0;
                bit_cnt   <= '0;
                pix_valid <= 1'b0;
                busy      <= 1'b0;
                buf_full  <= 1'b0;
                state     <= IDLE;
                vram_req  <= 1'b0;
            end else if (load_c) begin
                shreg     <= pf_data;
                buf_full  <= 1'b0;
                bit_cnt   <= '0;
                pix_valid <= 1'b1;
                disp_cnt  <= disp_next_c;
            end else if (urun_c) begin
                shreg     <= '0;
                underrun  <= 1'b1;
                bit_cnt   <= '0;
                disp_cnt  <= disp_next_c;
            end else if (pix_valid && ce) begin
                shreg   <= {shreg[DW-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end

            // Capture wins over a same-edge load, so the refilled buffer is not lost.
            if (capture_c && !end_c) begin
                pf_data  <= glyph_c;
                buf_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_charset_fetch_sequencer.sv
// Self-checking bench for charset_fetch_sequencer (COLS=4): directed and random lines checked
// against a cell-level model of the expected pixel, VRAM address and ROM address streams.
module tb_charset_fetch_sequencer;
    localparam int unsigned NCOL = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        line_start;
    logic [15:0] line_base;
    logic [2:0]  row;
    logic [1:0]  bank;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_data;
    logic        rom_ce;
    logic [12:0] rom_addr;
    logic [7:0]  rom_q;
    logic        pix;
    logic        pix_valid;
    logic        busy;
    logic        underrun;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  codes [NCOL];
    int          delays [NCOL];
    logic [15:0] cur_base;
    logic [2:0]  cur_row;
    logic [1:0]  cur_bank;
    logic        rand_ce = 1'b0;
    int          w = 0;
    int          valid_cnt = 0;
    logic        pix_q [$];
    logic [15:0] vaddr_q [$];
    logic [12:0] raddr_q [$];

    charset_fetch_sequencer #(.AW(13), .DW(8), .COLS(NCOL)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .line_start(line_start),
        .line_base(line_base), .row(row), .bank(bank),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_data(vram_data),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_q(rom_q),
        .pix(pix), .pix_valid(pix_valid), .busy(busy), .underrun(underrun)
    );

    always #5 clock = ~clock;

    function automatic logic [12:0] addr_of(input logic [1:0] b, input logic [7:0] code,
                                            input logic [2:0] r);
`ifdef CHARSET_INVERSE_EN
        return {b, 1'b0, code[6:0], r};
`else
        return {b, code, r};
`endif
    endfunction

    // ROM content is the low byte of its address; inverse codes show it complemented.
    function automatic logic [7:0] glyph_of(input logic [1:0] b, input logic [7:0] code,
                                            input logic [2:0] r);
        logic [12:0] a;
        logic [7:0]  g;
        a = addr_of(b, code, r);
        g = a[7:0];
`ifdef CHARSET_INVERSE_EN
        if (code[7]) g = ~g;
`endif
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: ROM and VRAM responders, then sample outputs 1 time unit after the edge.
    task automatic step();
        logic        rce;
        logic [12:0] ra;
        logic        was_ce;
        logic [15:0] off;
        int          ci;
        rce    = rom_ce;
        ra     = rom_addr;
        was_ce = ce;
        @(posedge clock);
        #1;
        rom_q = rce ? ra[7:0] : 8'($urandom);
        if (was_ce && pix_valid) pix_q.push_back(pix);
        if (pix_valid) valid_cnt++;
        if (rom_ce) raddr_q.push_back(rom_addr);
        if (vram_ack) begin
            vram_ack = 1'b0;
        end else if (vram_req) begin
            off = vram_addr - cur_base;
            ci  = int'(off[1:0]);
            if (w >= delays[ci]) begin
                vram_ack  = 1'b1;
                vram_data = codes[ci];
                vaddr_q.push_back(vram_addr);
                w = 0;
            end else begin
                w++;
            end
        end else begin
            w = 0;
        end
        ce         = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
        line_start = 1'b0;
    endtask

    task automatic start_line(input logic [15:0] b, input logic [2:0] r, input logic [1:0] bk);
        cur_base   = b;
        cur_row    = r;
        cur_bank   = bk;
        line_base  = b;
        row        = r;
        bank       = bk;
        line_start = 1'b1;
        pix_q.delete();
        vaddr_q.delete();
        raddr_q.delete();
        valid_cnt = 0;
        w = 0;
        step();
    endtask

    task automatic finish_line(input string tag, input int zero_col, input logic exp_urun,
                               input logic contig);
        int         n;
        logic [7:0] got;
        logic [7:0] exp;
        n = 0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        chk({tag, " line end"}, 32'(busy), 0);
        chk({tag, " pixel count"}, pix_q.size(), 8 * NCOL);
        if (contig) chk({tag, " valid cycles"}, valid_cnt, 8 * NCOL);
        if (pix_q.size() == 8 * NCOL) begin
            for (int c = 0; c < NCOL; c++) begin
                got = '0;
                for (int i = 0; i < 8; i++) got = {got[6:0], pix_q[c * 8 + i]};
                exp = (c == zero_col) ? 8'h00 : glyph_of(cur_bank, codes[c], cur_row);
                chk($sformatf("%s cell%0d", tag, c), 32'(got), 32'(exp));
            end
        end
        chk({tag, " vram reads"}, vaddr_q.size(), NCOL);
        if (vaddr_q.size() == NCOL) begin
            for (int c = 0; c < NCOL; c++)
                chk($sformatf("%s vram_addr%0d", tag, c), 32'(vaddr_q[c]),
                    32'(16'(cur_base + 16'(c))));
        end
        chk({tag, " rom reads"}, raddr_q.size(), NCOL);
        if (raddr_q.size() == NCOL) begin
            for (int c = 0; c < NCOL; c++)
                chk($sformatf("%s rom_addr%0d", tag, c), 32'(raddr_q[c]),
                    32'(addr_of(cur_bank, codes[c], cur_row)));
        end
        chk({tag, " underrun"}, 32'(underrun), 32'(exp_urun));
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        ce         = 1'b0;
        line_start = 1'b0;
        line_base  = '0;
        row        = '0;
        bank       = '0;
        vram_ack   = 1'b0;
        vram_data  = '0;
        rom_q      = '0;
        cur_base   = '0;
        cur_row    = '0;
        cur_bank   = '0;
        codes      = '{8'h00, 8'h00, 8'h00, 8'h00};
        delays     = '{1, 1, 1, 1};
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("rst vram_req", 32'(vram_req), 0);
        chk("rst vram_addr", 32'(vram_addr), 0);
        chk("rst rom_ce", 32'(rom_ce), 0);
        chk("rst rom_addr", 32'(rom_addr), 0);
        chk("rst pix", 32'(pix), 0);
        chk("rst pix_valid", 32'(pix_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst underrun", 32'(underrun), 0);
        repeat (2) step();

        // Basic line: codes 0x41..0x44, ack one clock after request.
        codes  = '{8'h41, 8'h42, 8'h43, 8'h44};
        delays = '{1, 1, 1, 1};
        start_line(16'h1000, 3'd5, 2'd2);
        finish_line("basic", -1, 1'b0, 1'b1);

        // Reset while a VRAM request is outstanding.
        delays = '{10, 10, 10, 10};
        start_line(16'h2345, 3'd1, 2'd1);
        n = 0;
        while (!vram_req && n < 20) begin
            step();
            n++;
        end
        chk("midrst req before", 32'(vram_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst vram_req", 32'(vram_req), 0);
        chk("midrst vram_addr", 32'(vram_addr), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst pix_valid", 32'(pix_valid), 0);
        chk("midrst rom_ce", 32'(rom_ce), 0);
        vram_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post-reset quiet req", 32'(vram_req), 0);
            chk("post-reset quiet busy", 32'(busy), 0);
        end

        // VRAM address wraps modulo 2^16.
        codes  = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        delays = '{1, 1, 1, 1};
        start_line(16'hFFFE, 3'd7, 2'd3);
        finish_line("wrap", -1, 1'b0, 1'b1);

        // Late ack on column 2: blank cell, sticky underrun, late byte dropped.
        codes  = '{8'h10, 8'h20, 8'h30, 8'h5A};
        delays = '{1, 1, 6, 1};
        start_line(16'h0400, 3'd2, 2'd0);
        finish_line("underrun", 2, 1'b1, 1'b1);

        // Restart a line at pixel 10 while a request is pending and underrun is set.
        codes  = '{8'h11, 8'h22, 8'h33, 8'h44};
        delays = '{1, 12, 1, 1};
        start_line(16'h0800, 3'd4, 2'd1);
        n = 0;
        while (pix_q.size() < 10 && n < 100) begin
            step();
            n++;
        end
        chk("abort pre pixels", pix_q.size(), 10);
        chk("abort pre underrun", 32'(underrun), 1);
        chk("abort pre vram_req", 32'(vram_req), 1);
        codes  = '{8'h61, 8'h62, 8'h63, 8'h64};
        delays = '{1, 1, 1, 1};
        start_line(16'h3000, 3'd6, 2'd2);
        chk("abort vram_req", 32'(vram_req), 0);
        chk("abort pix_valid", 32'(pix_valid), 0);
        chk("abort underrun", 32'(underrun), 0);
        chk("abort busy", 32'(busy), 1);
        step();
        chk("abort restart req", 32'(vram_req), 1);
        chk("abort restart addr", 32'(vram_addr), 32'h3000);
        finish_line("abort new", -1, 1'b0, 1'b1);

        // High-bit codes (inverse video when that build option is enabled).
        codes  = '{8'hC1, 8'h41, 8'h80, 8'hFF};
        delays = '{0, 2, 3, 1};
        start_line(16'h5000, 3'd3, 2'd1);
        finish_line("hibit", -1, 1'b0, 1'b1);

        // Random lines within the sustained-streaming ack latency, alternating ce patterns.
        for (int k = 0; k < 6; k++) begin
            rand_ce = k[0];
            for (int c = 0; c < NCOL; c++) begin
                codes[c]  = 8'($urandom);
                delays[c] = int'($urandom_range(0, 3));
            end
            start_line(16'($urandom), 3'($urandom), 2'($urandom));
            finish_line($sformatf("rand%0d", k), -1, 1'b0, !rand_ce);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
